wb_queue: RTL and testbench

- Writeback staging buffer between the execute-side result producers and the register file write port (we3/a3/wd3).
- Accepts results from the single-cycle ALU path and the multi-cycle mul/div unit, queues them in program order and retires one per cycle into the register file.
- Exposes RAW lookup on the two read addresses so the hazard/forwarding logic can see values not yet written back.

---
 rtl/wb_queue.sv | 131 +++++++++++++
 tb/tb_wb_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Writeback staging queue between execute-side result producers and the register file write port.
// Define WBQ_FWD_EN to build the RAW lookup on a1/a2; otherwise hit/fwd outputs are tied to zero.
module wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            md_valid,
  input  logic [4:0]      md_rd,
  input  logic [XLEN-1:0] md_data,
  output logic            in_ready,
  output logic            we3,
  output logic [4:0]      a3,
  output logic [XLEN-1:0] wd3,
  input  logic [4:0]      a1,
  input  logic [4:0]      a2,
  output logic            hit1,
  output logic            hit2,
  output logic [XLEN-1:0] fwd1,
  output logic [XLEN-1:0] fwd2,
  output logic            overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [4:0]      rd_q   [DEPTH];
  logic [4:0]      rd_d   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];

  logic            md_acc;
  logic            alu_acc;
  logic            deq;
  logic [PW-1:0]   alu_slot;

  assign in_ready = (count_q <= CW'(DEPTH - 2));
  assign deq      = (count_q != '0);
  assign md_acc   = in_ready && md_valid  && (md_rd  != '0);
  assign alu_acc  = in_ready && alu_valid && (alu_rd != '0);
  // mul/div result takes the tail slot first so it retires ahead of a same-cycle ALU result
  assign alu_slot = md_acc ? tail_q + PW'(1) : tail_q;

  always_comb begin
    rd_d       = rd_q;
    data_d     = data_q;
    overflow_d = overflow_q;
    if (md_acc) begin
      rd_d[tail_q]   = md_rd;
      data_d[tail_q] = md_data;
    end
    if (alu_acc) begin
      rd_d[alu_slot]   = alu_rd;
      data_d[alu_slot] = alu_data;
    end
    if (!in_ready && (md_valid || alu_valid)) begin
      overflow_d = 1'b1;
    end
    tail_d  = tail_q + PW'(md_acc) + PW'(alu_acc);
    head_d  = head_q + PW'(deq);
    count_d = count_q + CW'(md_acc) + CW'(alu_acc) - CW'(deq);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry payload needs no reset: validity is defined purely by head/count.
  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end

  assign we3      = deq;
  assign a3       = deq ? rd_q[head_q]   : '0;
  assign wd3      = deq ? data_q[head_q] : '0;
  assign overflow = overflow_q;

`ifdef WBQ_FWD_EN
  logic [PW-1:0] look_slot;

  // Walk oldest to youngest so the last match left standing is the youngest entry.
  always_comb begin
    hit1      = 1'b0;
    hit2      = 1'b0;
    fwd1      = '0;
    fwd2      = '0;
    look_slot = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      look_slot = head_q + PW'(k);
      if (k < 32'(count_q)) begin
        if ((a1 != '0) && (rd_q[look_slot] == a1)) begin
          hit1 = 1'b1;
          fwd1 = data_q[look_slot];
        end
        if ((a2 != '0) && (rd_q[look_slot] == a2)) begin
          hit2 = 1'b1;
          fwd2 = data_q[look_slot];
        end
      end
    end
  end
`else
  logic unused_lookup;

  assign unused_lookup = ^{a1, a2};
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
  assign fwd1 = '0;
  assign fwd2 = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: expected writebacks are queued at drive time and popped when we3 is seen.
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid, md_valid;
  logic [4:0]      alu_rd, md_rd;
  logic [XLEN-1:0] alu_data, md_data;
  logic            in_ready, we3;
  logic [4:0]      a3, a1, a2;
  logic [XLEN-1:0] wd3, fwd1, fwd2;
  logic            hit1, hit2, overflow;

  ent_t exp_q[$];
  int   mcount;
  logic exp_ovf;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data),
    .in_ready(in_ready), .we3(we3), .a3(a3), .wd3(wd3),
    .a1(a1), .a2(a2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
    .overflow(overflow)
  );

  // One clock cycle: pop/compare any writeback seen, then drive inputs and advance the reference model.
  task automatic step(input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                      input logic av, input logic [4:0] ard, input logic [31:0] adat);
    ent_t e;
    bit   rdy;
    int   n;
    @(negedge clk);
    if (we3 === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_write: got a3=%0d wd3=%h, required no write", a3, wd3);
      end else begin
        e = exp_q.pop_front();
        if (a3 !== e.rd || wd3 !== e.data) begin
          errors++;
          $display("FAIL wb_write: got a3=%0d wd3=%h, required a3=%0d wd3=%h", a3, wd3, e.rd, e.data);
        end
      end
    end
    md_valid = mv;  md_rd = mrd;  md_data = mdat;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    rdy = (mcount <= DEPTH - 2);
    n = 0;
    if (rdy) begin
      if (mv && mrd != 5'd0) begin exp_q.push_back('{rd: mrd, data: mdat}); n++; end
      if (av && ard != 5'd0) begin exp_q.push_back('{rd: ard, data: adat}); n++; end
    end else if (mv || av) begin
      exp_ovf = 1'b1;
    end
    mcount = mcount + n - ((mcount > 0) ? 1 : 0);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL reset_we3: got %b, required 0", we3); end
    checks++; if (a3 !== 5'd0) begin errors++; $display("FAIL reset_a3: got %0d, required 0", a3); end
    checks++; if (wd3 !== 32'd0) begin errors++; $display("FAIL reset_wd3: got %h, required 0", wd3); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    checks++;
    if ({hit1, hit2, fwd1, fwd2} !== '0) begin
      errors++;
      $display("FAIL reset_lookup: got hit1=%b hit2=%b fwd1=%h fwd2=%h, required all 0", hit1, hit2, fwd1, fwd2);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    step(0, 0, 0, 1, 5'd5, 32'h0000_00AA);
    @(posedge clk); #1;
    checks++;
    if (we3 !== 1'b1 || a3 !== 5'd5 || wd3 !== 32'h0000_00AA) begin
      errors++;
      $display("FAIL single_write: got we3=%b a3=%0d wd3=%h, required we3=1 a3=5 wd3=000000aa", we3, a3, wd3);
    end
    step(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL single_after: got we3=%b, required 0", we3); end
    idle(2);
  endtask

  task automatic test_pair();
    step(1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
    @(posedge clk); #1;
    checks++;
    if (we3 !== 1'b1 || a3 !== 5'd3 || wd3 !== 32'h11) begin
      errors++;
      $display("FAIL pair_first: got we3=%b a3=%0d wd3=%h, required we3=1 a3=3 wd3=00000011", we3, a3, wd3);
    end
    step(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    checks++;
    if (we3 !== 1'b1 || a3 !== 5'd4 || wd3 !== 32'h22) begin
      errors++;
      $display("FAIL pair_second: got we3=%b a3=%0d wd3=%h, required we3=1 a3=4 wd3=00000022", we3, a3, wd3);
    end
    idle(3);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL pair_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_x0_filter();
    step(1, 5'd0, 32'h1234_5678, 1, 5'd0, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL x0_we3: got %b, required 0", we3); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL x0_in_ready: got %b, required 1", in_ready); end
    idle(2);
  endtask

  task automatic test_forwarding();
    logic        eh1, eh2;
    logic [31:0] ef1, ef2;
    a1 = 5'd7; a2 = 5'd0;
    step(1, 5'd7, 32'h10, 1, 5'd7, 32'h20);
    @(posedge clk); #1;
`ifdef WBQ_FWD_EN
    eh1 = 1'b1; ef1 = 32'h20;
`else
    eh1 = 1'b0; ef1 = 32'h0;
`endif
    checks++;
    if (hit1 !== eh1 || fwd1 !== ef1) begin
      errors++;
      $display("FAIL fwd_youngest: got hit1=%b fwd1=%h, required hit1=%b fwd1=%h", hit1, fwd1, eh1, ef1);
    end
    checks++;
    if (hit2 !== 1'b0 || fwd2 !== 32'h0) begin
      errors++;
      $display("FAIL fwd_a2_zero: got hit2=%b fwd2=%h, required hit2=0 fwd2=0", hit2, fwd2);
    end
    a2 = 5'd9;
    step(1, 5'd8, 32'h30, 1, 5'd9, 32'h40);
    @(posedge clk); #1;
`ifdef WBQ_FWD_EN
    eh2 = 1'b1; ef2 = 32'h40;
`else
    eh2 = 1'b0; ef2 = 32'h0;
`endif
    checks++;
    if (hit1 !== eh1 || fwd1 !== ef1 || hit2 !== eh2 || fwd2 !== ef2) begin
      errors++;
      $display("FAIL fwd_three: got hit1=%b fwd1=%h hit2=%b fwd2=%h, required hit1=%b fwd1=%h hit2=%b fwd2=%h",
               hit1, fwd1, hit2, fwd2, eh1, ef1, eh2, ef2);
    end
    a1 = 5'd0; a2 = 5'd0;
    idle(5);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fwd_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_full_overflow();
    logic [2:0] rdy_seen;
    step(1, 5'd1, 32'h101, 1, 5'd2, 32'h102);
    #1 rdy_seen[0] = in_ready;
    step(1, 5'd3, 32'h103, 1, 5'd4, 32'h104);
    #1 rdy_seen[1] = in_ready;
    step(0, 0, 0, 1, 5'd5, 32'h105);
    #1 rdy_seen[2] = in_ready;
    checks++;
    if (rdy_seen !== 3'b011) begin
      errors++;
      $display("FAIL full_in_ready: got %b (cycle3..1), required 011", rdy_seen);
    end
    @(posedge clk); #1;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow: got %b, required 1", overflow); end
    idle(6);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_drain: got %0d pending, required 0", exp_q.size()); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_sticky: got %b, required 1", overflow); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    end
    idle(6);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); end
    checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL b2b_overflow: got %b, required %b", overflow, exp_ovf); end
  endtask

  task automatic test_async_reset();
    step(1, 5'd20, 32'hA0, 1, 5'd21, 32'hA1);
    step(1, 5'd22, 32'hA2, 1, 5'd23, 32'hA3);
    @(posedge clk); #2;
    checks++; if (we3 !== 1'b1) begin errors++; $display("FAIL areset_pre_we3: got %b, required 1", we3); end
    reset = 1'b1;
    #1;
    checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL areset_we3: got %b, required 0", we3); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready: got %b, required 1", in_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL areset_overflow: got %b, required 0", overflow); end
    #1 reset = 1'b0;
    exp_q.delete();
    mcount = 0;
    exp_ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL areset_post_we3: cycle %0d got %b, required 0", i, we3); end
    end
  endtask

  initial begin
    checks = 0; errors = 0; mcount = 0; exp_ovf = 1'b0;
    md_valid = 0; md_rd = 0; md_data = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    a1 = 0; a2 = 0;
    test_reset();
    test_single_write();
    test_pair();
    test_x0_filter();
    test_forwarding();
    test_full_overflow();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
